mem_readback_streamer: RTL and testbench

//  Reads a contiguous byte window from the configuration memory's flat
//  all-bytes bus and streams it out one byte per valid/ready handshake.
//  A trailing XOR checksum byte follows the data. Sits between the byte-wide

---
 rtl/mem_readback_streamer_pkg.sv | 16 +
 rtl/mem_readback_streamer_mux.sv | 30 +++
 rtl/mem_readback_streamer.sv | 153 +++++++++++++++
 tb/tb_mem_readback_streamer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_readback_streamer_pkg.sv
// Shared definitions for the config-memory readback streamer: sizing defaults,
// FSM state encoding and checksum seed.
package mem_readback_streamer_pkg;

  localparam int NUM_BYTES_DEFAULT = 102;
  localparam int ADDR_W_DEFAULT    = 8;

  localparam logic [7:0] CSUM_SEED = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CSUM = 2'd2
  } state_t;

endpackage

// File: rtl/mem_readback_streamer_mux.sv
// Combinational byte selector over the flat memory bus; out-of-range index
// yields 8'h00 so a stray pointer can never alias another byte.
module mem_byte_mux #(
  parameter int NUM_BYTES = 102,
  parameter int IDX_W     = 8
) (
  input  logic [NUM_BYTES*8-1:0] mem_flat,
  input  logic [IDX_W-1:0]       idx,
  output logic [7:0]             byte_out
);

  logic [7:0] mem_bytes [NUM_BYTES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_split
      assign mem_bytes[gi] = mem_flat[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    byte_out = 8'h00;
    for (int j = 0; j < NUM_BYTES; j++) begin
      if (int'(idx) == j) begin
        byte_out = mem_bytes[j];
      end
    end
  end

endmodule

// File: rtl/mem_readback_streamer.sv
// Streams a bounds-checked byte window of the config memory over valid/ready,
// followed by an XOR checksum byte flagged with out_last.
module mem_readback_streamer
  import mem_readback_streamer_pkg::*;
#(
  parameter int NUM_BYTES = NUM_BYTES_DEFAULT,
  parameter int ADDR_W    = ADDR_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      start_addr,
  input  logic [ADDR_W-1:0]      length,
  input  logic [NUM_BYTES*8-1:0] mem_flat,
  output logic                   busy,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   done,
  output logic                   err
);

  // Bound is evaluated one bit wider so start_addr+length cannot wrap.
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_BYTES);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic [ADDR_W-1:0] remaining_reg, remaining_next;
  logic [7:0]        csum_reg, csum_next;
  logic [7:0]        out_data_reg, out_data_next;
  logic              out_valid_reg, out_valid_next;
  logic              out_last_reg, out_last_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;

  logic [ADDR_W:0]   end_addr;
  logic              in_bounds;
  logic [ADDR_W-1:0] mux_idx;
  logic [7:0]        mux_byte;
  logic              hs;

  assign end_addr  = {1'b0, start_addr} + {1'b0, length};
  assign in_bounds = (end_addr <= LIMIT);
  assign mux_idx   = (state_reg == ST_IDLE) ? start_addr : ptr_reg;
  assign hs        = out_valid_reg & out_ready;

  mem_byte_mux #(
    .NUM_BYTES (NUM_BYTES),
    .IDX_W     (ADDR_W)
  ) u_mux (
    .mem_flat (mem_flat),
    .idx      (mux_idx),
    .byte_out (mux_byte)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= '0;
      remaining_reg <= '0;
      csum_reg      <= CSUM_SEED;
      out_data_reg  <= 8'h00;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      remaining_reg <= remaining_next;
      csum_reg      <= csum_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      out_last_reg  <= out_last_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    remaining_next = remaining_reg;
    csum_next      = csum_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;
    out_last_next  = out_last_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;
    err_next       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (!in_bounds) begin
            err_next = 1'b1;
          end else if (length == '0) begin
            done_next = 1'b1;
          end else begin
            out_data_next  = mux_byte;
            out_valid_next = 1'b1;
            out_last_next  = 1'b0;
            busy_next      = 1'b1;
            ptr_next       = start_addr + ADDR_W'(1);
            remaining_next = length - ADDR_W'(1);
            csum_next      = CSUM_SEED;
            state_next     = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (hs) begin
          csum_next = csum_reg ^ out_data_reg;
          if (remaining_reg == '0) begin
            out_data_next = csum_reg ^ out_data_reg;
            out_last_next = 1'b1;
            state_next    = ST_CSUM;
          end else begin
            // Sampled live at load time, so late memory writes are streamed.
            out_data_next  = mux_byte;
            ptr_next       = ptr_reg + ADDR_W'(1);
            remaining_next = remaining_reg - ADDR_W'(1);
          end
        end
      end

      ST_CSUM: begin
        if (hs) begin
          out_valid_next = 1'b0;
          out_last_next  = 1'b0;
          busy_next      = 1'b0;
          done_next      = 1'b1;
          state_next     = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign busy      = busy_reg;
  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign done      = done_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_mem_readback_streamer.sv
// Scoreboard bench for mem_readback_streamer: stimulus pushes hand-computed
// bytes, a negedge monitor pops and compares on every handshake.
module tb_mem_readback_streamer;

  localparam int NB = 102;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    start_addr;
  logic [7:0]    length;
  logic [NB*8-1:0] mem_flat;
  logic          busy;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  mem_readback_streamer #(
    .NUM_BYTES (NB),
    .ADDR_W    (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .mem_flat   (mem_flat),
    .busy       (busy),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .done       (done),
    .err        (err)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         err_cnt = 0;
  int         pending_cyc = -1;
  int         e0;
  bit         ready_toggle = 1'b0;
  logic       ready_level = 1'b1;
  bit         stall_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    sb.push_back(e);
  endtask

  task automatic do_start(input logic [7:0] a, input logic [7:0] l);
    @(posedge clk);
    #1;
    start      = 1'b1;
    start_addr = a;
    length     = l;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got timeout after %0d cycles expected idle", n);
    end
    repeat (2) @(negedge clk);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_toggle) out_ready = ~out_ready;
      else              out_ready = ready_level;
    end
  end

  // Monitor: pops on each handshake, checks hold-while-stalled and done timing.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_prev  = 1'b0;
        pending_cyc = -1;
      end else begin
        if (err) err_cnt++;
        if (pending_cyc >= 0 && cyc == pending_cyc) begin
          chk("done_after_last", {31'd0, done}, 32'd1);
          pending_cyc = -1;
        end
        if (stall_prev) chk("hold_while_stalled", {23'd0, out_valid, out_data}, {23'd0, 1'b1, prev_data});
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h expected no valid", out_data);
          end else begin
            mon_e = sb.pop_front();
            chk("stream_data", {24'd0, out_data}, {24'd0, mon_e.d});
            chk("stream_last", {31'd0, out_last}, {31'd0, mon_e.l});
            if (mon_e.l) pending_cyc = cyc + 1;
          end
        end
        stall_prev = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    start_addr = 8'd0;
    length     = 8'd0;
    for (int j = 0; j < NB; j++) mem_flat[j*8 +: 8] = 8'(j);
    repeat (3) @(negedge clk);
    chk("reset_outputs", {19'd0, out_data, out_valid, out_last, busy, done, err}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Basic window, ready held high
    push(8'h0A, 1'b0); push(8'h0B, 1'b0); push(8'h0C, 1'b0); push(8'h0D, 1'b1);
    do_start(8'd10, 8'd3);
    @(negedge clk);
    chk("first_valid_latency", {31'd0, out_valid}, 32'd1);
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    wait_idle();
    $display("txn1 addr=10 len=3 ready=1 complete");

    // Same window with ready toggling
    ready_toggle = 1'b1;
    push(8'h0A, 1'b0); push(8'h0B, 1'b0); push(8'h0C, 1'b0); push(8'h0D, 1'b1);
    do_start(8'd10, 8'd3);
    wait_idle();
    ready_toggle = 1'b0;
    ready_level  = 1'b1;
    $display("txn2 addr=10 len=3 ready toggling complete");

    // Out of bounds, then exactly at the top boundary
    do_start(8'd100, 8'd3);
    @(negedge clk);
    chk("oob_err_pulse", {31'd0, err}, 32'd1);
    chk("oob_no_valid_busy", {30'd0, out_valid, busy}, 32'd0);
    @(negedge clk);
    chk("oob_err_one_cycle", {31'd0, err}, 32'd0);
    repeat (3) @(negedge clk);
    push(8'h63, 1'b0); push(8'h64, 1'b0); push(8'h65, 1'b0); push(8'h62, 1'b1);
    do_start(8'd99, 8'd3);
    wait_idle();
    $display("txn3 addr=100 rejected, addr=99 len=3 complete");

    // Zero length
    do_start(8'd5, 8'd0);
    @(negedge clk);
    chk("len0_done_pulse", {31'd0, done}, 32'd1);
    chk("len0_no_valid_busy", {30'd0, out_valid, busy}, 32'd0);
    @(negedge clk);
    chk("len0_done_one_cycle", {30'd0, done, busy}, 32'd0);
    $display("txn4 addr=5 len=0 complete");

    // Start while busy is ignored
    e0 = err_cnt;
    push(8'h1E, 1'b0); push(8'h1F, 1'b0); push(8'h20, 1'b0); push(8'h21, 1'b0); push(8'h00, 1'b1);
    do_start(8'd30, 8'd4);
    do_start(8'd0, 8'd2);
    wait_idle();
    chk("busy_start_no_err", e0, err_cnt);
    $display("txn5a addr=30 len=4 with ignored start complete");

    // Reset mid-stream while stalled
    ready_level = 1'b0;
    do_start(8'd40, 8'd5);
    @(negedge clk);
    chk("stalled_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("midreset_outputs_low", {29'd0, out_valid, busy, out_last}, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    ready_level = 1'b1;
    push(8'h0A, 1'b0); push(8'h0B, 1'b0); push(8'h0C, 1'b0); push(8'h0D, 1'b1);
    do_start(8'd10, 8'd3);
    wait_idle();
    $display("txn5b mid-stream reset then addr=10 len=3 complete");

    // Live memory write ahead of load
    push(8'h00, 1'b0); push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'hAA, 1'b0); push(8'hA9, 1'b1);
    do_start(8'd0, 8'd4);
    mem_flat[3*8 +: 8] = 8'hAA;
    wait_idle();
    mem_flat[3*8 +: 8] = 8'h03;
    $display("txn6 addr=0 len=4 with live write complete");

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
